// File: rtl/uart_rx_frame.sv
// UART receive front-end: 2-flop synchroniser, glitch-rejecting start detect, mid-bit sampling,
// stop-bit framing, overrun detection and a valid/ack output. Parity is compiled in with UART_RX_PARITY_EN.
module uart_rx_frame #(
    parameter int BIT_TICKS  = 5208,
    parameter int DATA_BITS  = 8,
    parameter int CNT_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_vld,
    output logic                 frame_err,
    output logic                 par_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF  = BIT_TICKS / 2;
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]           sync_q;
    logic                 rxs;
    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 bit_end;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_vld_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    logic                 par_bad_q;
    logic                 par_err_q;
`endif

    assign rxs     = sync_q[1];
    assign cnt_d   = cnt_q + CNT_W'(1);
    assign bit_end = (cnt_q == BIT_LAST);

    // Idle-high reset value keeps a reset release from looking like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_vld_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            if (rx_vld_q && rx_ack) begin
                rx_vld_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (rxs) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == HALF_LAST) begin
                        state_q <= S_DATA;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        // LSB arrives first, so shifting in from the top lands it in bit 0.
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        par_bad_q <= rxs ^ (^shift_q) ^ ODD_BIT;
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (!rxs) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                par_err_q <= 1'b1;
                            end else
`endif
                            begin
                                rx_data_q <= shift_q;
                                rx_vld_q  <= 1'b1;
                                overrun_q <= rx_vld_q && !rx_ack;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_vld    = rx_vld_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign par_err   = par_err_q;
`else
    // Without parity the sense parameter has no effect; the output is constant low.
    assign par_err   = 1'b0 & (PARITY_ODD != 0);
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: vector table, hand-built corner sequences and random frames
// checked against a frame-level outcome model (deliver / frame error / parity error / overrun).
module tb_uart_rx_frame;

    localparam int BT   = 16;
    localparam int DB   = 8;
    localparam int HALF = BT / 2;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_CYC = (DB + P + 2) * BT;
    // rxd edge -> rxs (2) -> START entry (1) -> stop sample -> registered result
    localparam int LAT = 3 + HALF + (DB + P + 1) * BT;

    typedef struct {
        logic [7:0] data;
        bit         par_ok;
        bit         stop_bit;
        int         hold_low;
        bit         do_ack;
        bit         exp_vld;
        logic [7:0] exp_data;
        bit         exp_fe;
        bit         exp_pe;
        bit         exp_ov;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rxd = 1'b1;
    logic          rx_ack = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_vld;
    logic          frame_err;
    logic          par_err;
    logic          overrun;
    logic          busy;

    uart_rx_frame #(
        .BIT_TICKS (BT),
        .DATA_BITS (DB),
        .CNT_W     (16),
        .PARITY_ODD(PODD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .frame_err(frame_err),
        .par_err  (par_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Event monitor: counts pulses and records when rx_vld rises.
    int n_fe = 0, n_pe = 0, n_ov = 0, n_rise = 0, rise_cyc = 0;
    bit vld_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_vld === 1'b1 && !vld_prev) begin
            n_rise   = n_rise + 1;
            rise_cyc = cyc;
        end
        vld_prev = (rx_vld === 1'b1);
        if (frame_err === 1'b1) n_fe = n_fe + 1;
        if (par_err === 1'b1)   n_pe = n_pe + 1;
        if (overrun === 1'b1)   n_ov = n_ov + 1;
    end

    int total = 0;
    int bad   = 0;
    bit         mv = 1'b0;   // model: character pending
    logic [7:0] md = 8'h00;  // model: last delivered character

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total = total + 1;
        if (act !== exp_v) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame on rxd, one cycle per iteration; rx_ack is high for iteration ack_k only.
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_bit,
                              input int ack_k, input int n_cyc);
        bit w[DB+P+2];
        w[0] = 1'b0;
        for (int i = 0; i < DB; i++) w[1+i] = d[i];
        if (P != 0) w[DB+1] = (^d) ^ (PODD != 0) ^ !par_ok;
        w[DB+P+1] = stop_bit;
        for (int k = 0; k < n_cyc; k++) begin
            rxd    = w[k / BT];
            rx_ack = (k == ack_k);
            step();
        end
        rx_ack = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit par_ok,
                             input bit stop_bit, input int hold_low, input bit do_ack,
                             input bit e_vld, input logic [7:0] e_data, input bit e_fe,
                             input bit e_pe, input bit e_ov, input int gap);
        int fe0, pe0, ov0, r0, c0;
        bit rise_exp;
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; r0 = n_rise;
        rise_exp = e_vld && !mv;
        c0 = cyc;
        send_frame(d, par_ok, stop_bit, -1, FRAME_CYC);
        if (!stop_bit) begin
            rxd = 1'b0;
            repeat (hold_low) step();
            check({tag, "_break_busy"}, 32'(busy), 32'd1);
            rxd = 1'b1;
            repeat (6) step();
            check({tag, "_break_exit"}, 32'(busy), 32'd0);
        end
        check({tag, "_frame_err"}, n_fe - fe0, 32'(e_fe));
        check({tag, "_par_err"}, n_pe - pe0, 32'(e_pe));
        check({tag, "_overrun"}, n_ov - ov0, 32'(e_ov));
        check({tag, "_vld_rise"}, n_rise - r0, 32'(rise_exp));
        check({tag, "_vld"}, 32'(rx_vld), 32'(e_vld));
        check({tag, "_data"}, 32'(rx_data), 32'(e_data));
        if (rise_exp) check({tag, "_latency"}, rise_cyc - c0, LAT);
        $display("frame %s: data=%02h stop=%0d par_ok=%0d -> vld=%0d rx_data=%02h fe=%0d pe=%0d ov=%0d",
                 tag, d, stop_bit, par_ok, rx_vld, rx_data, n_fe - fe0, n_pe - pe0, n_ov - ov0);
        if (do_ack) begin
            rx_ack = 1'b1;
            step();
            rx_ack = 1'b0;
            if (e_vld) check({tag, "_ack_clear"}, 32'(rx_vld), 32'd0);
        end
        mv = do_ack ? 1'b0 : e_vld;
        md = e_data;
        repeat (gap) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int fe0, pe0, ov0, r0;
        logic [7:0] d;
        bit par_ok, stop_bit, do_ack, e_vld, e_fe, e_pe, e_ov;
        logic [7:0] e_data;
        int hold, gap, glen;

        vecs.push_back('{8'hA5, 1'b1, 1'b1, 0,  1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h3C, 1'b1, 1'b0, 40, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h11, 1'b1, 1'b1, 0,  1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h22, 1'b1, 1'b1, 0,  1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 0,  1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 0,  1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 0,  1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 1'b0, 1'b1, 0,  1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h5A, 1'b0, 1'b0, 0,  1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 1'b1, 1'b1, 0,  1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0});
`endif

        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_vld", 32'(rx_vld), 32'd0);
        check("reset_fe", 32'(frame_err), 32'd0);
        check("reset_pe", 32'(par_err), 32'd0);
        check("reset_ov", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        step();

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par_ok, vecs[i].stop_bit,
                      vecs[i].hold_low, vecs[i].do_ack, vecs[i].exp_vld, vecs[i].exp_data,
                      vecs[i].exp_fe, vecs[i].exp_pe, vecs[i].exp_ov, 2);
        end

        // Start-bit glitches shorter than half a bit
        fe0 = n_fe; r0 = n_rise;
        rxd = 1'b0;
        repeat (4) step();
        check("glitch_busy", 32'(busy), 32'd1);
        step();
        rxd = 1'b1;
        repeat (8) step();
        check("glitch_idle", 32'(busy), 32'd0);
        for (int g = 0; g < 4; g++) begin
            glen = $urandom_range(1, HALF - 1);
            rxd = 1'b0;
            repeat (glen) step();
            rxd = 1'b1;
            repeat (8) step();
            check($sformatf("glitch%0d_idle", glen), 32'(busy), 32'd0);
        end
        repeat (2 * BT) step();
        check("glitch_no_vld", n_rise - r0, 32'd0);
        check("glitch_no_fe", n_fe - fe0, 32'd0);
        $display("glitch: busy=%0d vld=%0d", busy, rx_vld);

        // Ack on the delivery cycle of a second, back-to-back character
        run_frame("simul_a", 8'h11, 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 0);
        ov0 = n_ov; r0 = n_rise;
        send_frame(8'h22, 1'b1, 1'b1, LAT - 1, FRAME_CYC);
        check("simul_vld", 32'(rx_vld), 32'd1);
        check("simul_data", 32'(rx_data), 32'h22);
        check("simul_no_ov", n_ov - ov0, 32'd0);
        check("simul_no_rise", n_rise - r0, 32'd0);
        $display("frame simul_b: data=22 -> vld=%0d rx_data=%02h ov=%0d", rx_vld, rx_data, n_ov - ov0);
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        check("simul_ack_clear", 32'(rx_vld), 32'd0);
        mv = 1'b0;
        md = 8'h22;

        // Reset in the middle of a data bit, with a character pending
        run_frame("rst_pre", 8'h33, 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b1, -1, 5 * BT);
        check("rst_mid_busy", 32'(busy), 32'd1);
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        rst = 1'b1;
        #1;
        check("rst_mid_data", 32'(rx_data), 32'd0);
        check("rst_mid_vld", 32'(rx_vld), 32'd0);
        check("rst_mid_busy0", 32'(busy), 32'd0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step();
        check("rst_no_fe", n_fe - fe0, 32'd0);
        check("rst_no_pe", n_pe - pe0, 32'd0);
        check("rst_no_ov", n_ov - ov0, 32'd0);
        check("rst_idle", 32'(busy), 32'd0);
        $display("reset mid-frame: vld=%0d rx_data=%02h busy=%0d", rx_vld, rx_data, busy);
        mv = 1'b0;
        md = 8'h00;
        run_frame("rst_post", 8'h5A, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 2);

        // Random frames against the outcome model
        for (int i = 0; i < 30; i++) begin
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 7) != 0);
            if (P != 0) par_ok = ($urandom_range(0, 7) != 0);
            else        par_ok = 1'b1;
            hold     = $urandom_range(0, 24);
            do_ack   = ($urandom_range(0, 3) != 0);
            gap      = stop_bit ? $urandom_range(0, 3) : 0;
            e_fe = 1'b0; e_pe = 1'b0; e_ov = 1'b0;
            e_vld = mv; e_data = md;
            if (!stop_bit) begin
                e_fe = 1'b1;
            end else if (!par_ok) begin
                e_pe = 1'b1;
            end else begin
                e_ov   = mv;
                e_vld  = 1'b1;
                e_data = d;
            end
            run_frame($sformatf("rnd%0d", i), d, par_ok, stop_bit, hold, do_ack,
                      e_vld, e_data, e_fe, e_pe, e_ov, gap);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive front-end that turns the raw serial line into complete, validated characters. It provides:

- input synchronisation and start-bit glitch rejection;
- mid-bit sampling and configurable data width;
- optional parity, stop-bit framing check and overrun detection;
- a valid/ack handshake toward the debug unit's command parser.

It replaces the bare start-bit/sampling-phase counter in the serial receive path.

## Interface

- BIT_TICKS, 5208, clk cycles per bit (≥ 4); HALF = BIT_TICKS/2 (integer division)
- DATA_BITS, 8, data bits per frame (5..9)
- CNT_W, 16, counter width; must satisfy 2^CNT_W > BIT_TICKS
- PARITY_ODD, 0, 1 = odd parity, 0 = even (only meaningful with parity compiled in)

Ports:

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rxd  in  1  raw serial line, idle high, asynchronous to clk
- rx_ack  in  1  consumer accepts rx_data while rx_vld=1
- rx_data  out  DATA_BITS  received character, LSB = first bit on the wire
- rx_vld  out  1  rx_data valid; held until acknowledged
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- par_err  out  1  one-cycle pulse: parity mismatch
- overrun  out  1  one-cycle pulse: unacknowledged character overwritten
- busy  out  1  high in every state except IDLE

## Operation

- **Input synchronisation:** rxd passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised line rxs.
- **IDLE:** cnt=0. rxs=0 → START.
- **START:** cnt increments each cycle.
  - rxs=1 before completion → IDLE, cnt=0 (glitch rejected).
  - cnt==HALF-1 with rxs=0 → DATA, cnt=0, bit index=0.
- **DATA:** cnt increments. At cnt==BIT_TICKS-1:
  - sample rxs into shift register bit[index], cnt=0;
  - after bit DATA_BITS-1 → PARITY (if compiled in) else STOP.
- **PARITY:** at cnt==BIT_TICKS-1, sample rxs and compare with the XOR of the data bits (XOR-inverted when PARITY_ODD=1); then → STOP.
- **STOP:** at cnt==BIT_TICKS-1, sample rxs.
  - rxs=1 and no parity error → deliver the character; → IDLE.
  - rxs=1 and parity error → par_err pulse, character discarded; → IDLE.
  - rxs=0 → frame_err pulse, character discarded; → BREAK.
- **BREAK:** wait for rxs=1, then → IDLE. Prevents a held-low line from re-triggering START.
- **Delivery:** rx_data loaded from the shift register, rx_vld=1.
- **Handshake:** rx_vld clears on the cycle after rx_ack=1 while rx_vld=1. rx_ack while rx_vld=0 is ignored.
- **Overrun:** delivery while rx_vld=1 and rx_ack=0 overwrites rx_data and pulses overrun; rx_vld stays 1.
- **Simultaneous ack and delivery:** rx_vld stays 1 with the new data; no overrun pulse.
- **Error priority:** a frame with both a parity error and a bad stop bit pulses frame_err only.
- **Arithmetic:** cnt compares are exact-equality in CNT_W bits; cnt never exceeds BIT_TICKS-1.

## Timing

- **Reset values:** rx_data=0, rx_vld=0, frame_err=0, par_err=0, overrun=0, busy=0; state=IDLE, cnt=0. rst mid-frame aborts immediately with no pulses.
- **Synchroniser:** 2 cycles from an rxd edge to rxs.
- **START:** entered the cycle after rxs falls. A low pulse on rxs shorter than HALF cycles never reaches DATA.
- **Bit sample points:** first data-bit sample HALF+BIT_TICKS cycles after START entry; each later bit BIT_TICKS cycles after the previous one.
- **Stop sample:** occurs (DATA_BITS+P)·BIT_TICKS + HALF + BIT_TICKS cycles after START entry, where P=1 if parity is compiled in, else 0.
- **Result outputs:** rx_vld and the error pulses are registered and go high the cycle after the stop sample.
- **Back-to-back frames:** next START may begin the cycle after STOP, giving full back-to-back throughput with no idle gap required beyond the stop bit.
- **busy:** registered; equals (state != IDLE).

## Configuration

- **UART_RX_PARITY_EN defined:**
  - PARITY state present; one parity bit expected between the last data bit and the stop bit;
  - par_err is driven;
  - PARITY_ODD selects the sense.
- **UART_RX_PARITY_EN undefined:**
  - no PARITY state; DATA goes directly to STOP;
  - par_err is tied 0;
  - PARITY_ODD is ignored.

## Test plan

All scenarios use BIT_TICKS=16, DATA_BITS=8.

1. Frame 0xA5, 8N1 -> rx_data=0xA5, rx_vld=1 until rx_ack; frame_err=par_err=overrun=0.
2. rxd low for 5 cycles, then high -> state returns to IDLE; rx_vld never rises; busy falls within 8 cycles.
3. Frame 0x3C with stop bit 0, line held low for 40 cycles -> frame_err pulse, rx_vld=0, busy=1 until rxs=1, no new START while low.
4. Two frames 0x11 then 0x22, no ack -> rx_data=0x22, overrun pulse once. Repeat with rx_ack asserted on the delivery cycle -> no overrun.
5. With UART_RX_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity 1 -> rx_data=0x07. Same frame with parity 0 -> par_err pulse, rx_vld=0.
6. rst asserted mid-DATA of 0xFF -> all outputs 0, busy=0. A following frame 0x5A is received correctly.
